// File: rtl/out_wb_fifo.sv
// rtl/out_wb_fifo.sv - write-back FIFO between the PPU output strobes and a valid/ready consumer
module out_wb_fifo #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_out_we,
    input  logic [DATA_W-1:0] i_out_data,
    input  logic [ADDR_W-1:0] i_out_addr,
    input  logic              i_finish,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [DATA_W-1:0] o_m_data,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic              o_m_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic [CNT_W-1:0]  o_beat_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [OCC_W-1:0] FULL_C = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic [OCC_W-1:0] count_d;
    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             overflow_q;
    logic [CNT_W-1:0] beat_cnt_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_drop;
    logic [ENT_W-1:0] head_ent;

    // A pop frees the head slot this edge, so a full FIFO may still take a write alongside it
    assign fifo_pop  = o_m_valid && i_m_ready;
    assign fifo_push = i_out_we && ((count_q < FULL_C) || fifo_pop);
    assign fifo_drop = i_out_we && !fifo_push;

    assign head_ent   = mem_q[rd_ptr_q];
    assign o_m_valid  = (count_q != '0);
    assign o_m_addr   = head_ent[ENT_W-1:DATA_W];
    assign o_m_data   = head_ent[DATA_W-1:0];
    assign o_m_last   = o_m_valid && (state_q == S_DRAIN) && (count_q == OCC_W'(1)) && !i_out_we;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overflow = overflow_q;
    assign o_beat_cnt = beat_cnt_q;

    // Next occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        if (fifo_push && !fifo_pop) begin
            count_d = count_q + 1'b1;
        end else if (fifo_pop && !fifo_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Entry storage and wrapping pointers; reset discards all contents
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_push) begin
                mem_q[wr_ptr_q] <= {i_out_addr, i_out_data};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Matrix state machine with registered busy/done, sticky overflow and beat counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            if (fifo_pop && (beat_cnt_q != '1)) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end
            done_q <= 1'b0;
            busy_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (i_out_we) begin
                        state_q    <= S_ACTIVE;
                        busy_q     <= 1'b1;
                        overflow_q <= 1'b0;
                        beat_cnt_q <= '0;
                    end else if (i_finish) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (i_finish) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Late pushes keep the drain alive; finish is ignored here
                    if ((count_d == '0) && !fifo_push) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_out_we) begin
                        state_q    <= S_ACTIVE;
                        overflow_q <= 1'b0;
                        beat_cnt_q <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_wb_fifo.sv
// tb/tb_out_wb_fifo.sv - scoreboard bench for out_wb_fifo
module tb_out_wb_fifo;

    localparam int S_IDLE   = 0;
    localparam int S_ACTIVE = 1;
    localparam int S_DRAIN  = 2;
    localparam int S_DONE   = 3;

    typedef struct packed {
        logic [15:0]  a;
        logic [127:0] d;
    } ent_t;

    logic         clk;
    logic         rst_n;
    logic         we;
    logic [127:0] wdata;
    logic [15:0]  waddr;
    logic         fin;
    logic         m_valid;
    logic         ready;
    logic [127:0] m_data;
    logic [15:0]  m_addr;
    logic         m_last;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [15:0]  beats;

    out_wb_fifo dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_out_we   (we),
        .i_out_data (wdata),
        .i_out_addr (waddr),
        .i_finish   (fin),
        .o_m_valid  (m_valid),
        .i_m_ready  (ready),
        .o_m_data   (m_data),
        .o_m_addr   (m_addr),
        .o_m_last   (m_last),
        .o_busy     (busy),
        .o_done     (done),
        .o_overflow (ovf),
        .o_beat_cnt (beats)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    ent_t        sb[$];
    logic [15:0] popped[$];
    int          m_cnt   = 0;
    int          m_st    = S_IDLE;
    logic        m_ovf   = 1'b0;
    logic [15:0] m_beats = '0;
    int          n_done  = 0;
    int          n_lastpop = 0;
    logic [15:0] last_addr = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_data(input logic [15:0] a);
        logic [7:0] b;
        b = 8'(a[7:0] * 8'h11);
        return {16{b}};
    endfunction

    // One clock: check outputs mid-cycle against the model, then advance the model
    task automatic cycle();
        logic pop, push, drop, exp_last;
        ent_t h;
        int   nc;
        @(negedge clk);
        exp_last = (m_cnt == 1) && (m_st == S_DRAIN) && !we;
        check("valid", m_valid, m_cnt != 0);
        check("last", m_last, exp_last);
        check("done", done, m_st == S_DONE);
        check("busy", busy, m_st != S_IDLE);
        check("overflow", ovf, m_ovf);
        check("beat_cnt", beats, m_beats);
        if (m_cnt != 0) begin
            h = sb[0];
            check("head_addr", m_addr, h.a);
            check("head_data", m_data, h.d);
        end
        if (done) n_done++;
        pop = (m_cnt != 0) && ready;
        if (pop) begin
            void'(sb.pop_front());
            popped.push_back(m_addr);
            if (m_last) begin
                n_lastpop++;
                last_addr = m_addr;
            end
        end
        push = we && ((m_cnt < 8) || pop);
        drop = we && !push;
        if (push) sb.push_back({waddr, wdata});
        nc = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
        if (pop && (m_beats != 16'hFFFF)) m_beats++;
        if (drop) m_ovf = 1'b1;
        case (m_st)
            S_IDLE: begin
                if (we) begin
                    m_st = S_ACTIVE; m_ovf = 1'b0; m_beats = '0;
                end else if (fin) begin
                    m_st = S_DONE;
                end
            end
            S_ACTIVE: if (fin) m_st = S_DRAIN;
            S_DRAIN:  if ((nc == 0) && !push) m_st = S_DONE;
            default: begin
                if (we) begin
                    m_st = S_ACTIVE; m_ovf = 1'b0; m_beats = '0;
                end else begin
                    m_st = S_IDLE;
                end
            end
        endcase
        m_cnt = nc;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a);
        we    = 1'b1;
        waddr = a;
        wdata = mk_data(a);
        cycle();
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int          d0;
    logic [15:0] pos_addr;

    initial begin
        clk = 1'b0; rst_n = 1'b0; we = 1'b0; wdata = '0; waddr = '0; fin = 1'b0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", m_valid, 1'b0);
        check("rst_data", m_data, '0);
        check("rst_addr", m_addr, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_beats", beats, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic flow: finish alongside the 4th write so addr 3 is the drained last beat
        ready = 1'b1; d0 = n_done; n_lastpop = 0; popped.delete();
        wr(16'h0); wr(16'h1); wr(16'h2);
        fin = 1'b1; wr(16'h3); fin = 1'b0;
        idle(4);
        check("basic_beats", popped.size(), 4);
        check("basic_last_cnt", n_lastpop, 1);
        check("basic_last_addr", last_addr, 16'h3);
        check("basic_done_cnt", n_done - d0, 1);
        check("basic_beat_cnt", beats, 16'd4);
        check("basic_ovf", ovf, 1'b0);

        // Back-pressure: fill 8, drop a 9th, then drain exactly 8
        ready = 1'b0; popped.delete();
        for (int i = 0; i < 8; i++) wr(16'h10 + 16'(i));
        idle(2);
        wr(16'h99);
        check("bp_overflow", ovf, 1'b1);
        ready = 1'b1;
        idle(9);
        fin = 1'b1; cycle(); fin = 1'b0;
        idle(3);
        check("bp_beats", popped.size(), 8);
        check("bp_beat_cnt", beats, 16'd8);

        // Full with simultaneous push and pop
        ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(16'h30 + 16'(i));
        ready = 1'b1;
        wr(16'h20);
        popped.delete();
        idle(9);
        fin = 1'b1; cycle(); fin = 1'b0;
        idle(3);
        check("fpp_count", popped.size(), 8);
        pos_addr = (popped.size() > 7) ? popped[7] : 16'hxxxx;
        check("fpp_pos8", pos_addr, 16'h20);
        check("fpp_ovf", ovf, 1'b0);
        check("fpp_beat_cnt", beats, 16'd9);

        // Late write during drain
        ready = 1'b0; n_lastpop = 0; d0 = n_done;
        wr(16'h6);
        fin = 1'b1; cycle(); fin = 1'b0;
        cycle();
        wr(16'h7);
        ready = 1'b1;
        idle(4);
        check("late_last_cnt", n_lastpop, 1);
        check("late_last_addr", last_addr, 16'h7);
        check("late_done_cnt", n_done - d0, 1);

        // Empty matrix
        d0 = n_done; popped.delete();
        fin = 1'b1; cycle(); fin = 1'b0;
        idle(3);
        check("empty_done_cnt", n_done - d0, 1);
        check("empty_beats", popped.size(), 0);
        check("empty_beat_cnt", beats, 16'd2);

        // Mid-run reset with entries pending
        ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(16'h40 + 16'(i));
        ready = 1'b1; cycle(); ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", m_valid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_ovf", ovf, 1'b0);
        check("mrst_beats", beats, '0);
        check("mrst_addr", m_addr, '0);
        sb.delete(); m_cnt = 0; m_st = S_IDLE; m_ovf = 1'b0; m_beats = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        d0 = n_done;
        idle(5);
        check("mrst_no_done", n_done - d0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/out_wb_fifo.md
# out_wb_fifo

Write-back buffer directly downstream of the post-processing unit. It captures the PPU's output-RAM write strobes (`we` / `data` / `addr`) into a small FIFO and drains them to the output RAM / host bus through a valid/ready handshake. It also tracks end-of-matrix via the PPU finish pulse and reports last-beat, done, beat count and overflow. This decouples PPU write timing from a back-pressured consumer.

## Interface
Parameters:
- `DATA_W`, default 128: one write word, `DATA8_W * VL` (8 × 16).
- `ADDR_W`, default 16: output RAM address width.
- `DEPTH`, default 8: FIFO entries; must be a power of two, ≥ 2.
- `CNT_W`, default 16: beat counter width.

Ports (clock and reset first):
- `i_clk`  in  1  clock; everything is rising-edge.
- `i_rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `i_out_we`  in  1  PPU write strobe; one entry per high cycle.
- `i_out_data`  in  DATA_W  PPU write data.
- `i_out_addr`  in  ADDR_W  PPU write address.
- `i_finish`  in  1  PPU end-of-matrix pulse.
- `o_m_valid`  out  1  head entry available.
- `i_m_ready`  in  1  consumer accepts the head entry.
- `o_m_data`  out  DATA_W  head data.
- `o_m_addr`  out  ADDR_W  head address.
- `o_m_last`  out  1  head is the final beat of the matrix.
- `o_busy`  out  1  state ≠ IDLE.
- `o_done`  out  1  one-cycle pulse when the matrix is fully drained.
- `o_overflow`  out  1  sticky: a write was dropped.
- `o_beat_cnt`  out  CNT_W  handshakes completed in the current matrix.

## Operation
- Storage:
  - Register array of {addr, data}.
  - Write pointer and read pointer are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy `count` is 0..DEPTH.
- Push = `i_out_we` && (`count` < DEPTH || pop). When full, a simultaneous pop and push is accepted and count is unchanged.
- Pop = `o_m_valid` && `i_m_ready`.
- Dropped write (`i_out_we` while full, no pop): the entry is discarded and `o_overflow` sets. Pointers do not move.
- `o_m_valid` = (`count` != 0).
- `o_m_data` and `o_m_addr` come from the head register and hold stable while valid and not popped.
- States:
  - IDLE: `o_beat_cnt` holds its last value.
    - → ACTIVE on `i_out_we`. On this transition `o_overflow` and `o_beat_cnt` clear.
    - → DONE on `i_finish` with `i_out_we` low (empty matrix).
  - ACTIVE: pushes and pops run.
    - → DRAIN on `i_finish`. A push in the same cycle is accepted.
  - DRAIN: pushes are still accepted and extend the drain. `i_finish` is ignored.
    - → DONE when `count` becomes 0 with no push.
  - DONE: `o_done` = 1 for exactly this cycle.
    - → IDLE.
    - An `i_out_we` in DONE is accepted into the FIFO and moves to ACTIVE, clearing the counters.
- `o_m_last` = `o_m_valid` && state==DRAIN && `count`==1 && !`i_out_we`. It is combinational from state and inputs. It can drop if a late push arrives before the handshake.
- `o_beat_cnt` increments on each pop and saturates at all-ones.
- `i_finish` in IDLE with an empty FIFO gives `o_done` with no beats and no `o_m_last`.

## Timing
- Reset values:
  - State IDLE, pointers 0, `count` 0.
  - All outputs 0, including data/addr.
- Latency: a push at edge t makes `o_m_valid` high after edge t; the consumer can pop in cycle t+1. No combinational path from `i_out_we` to `o_m_valid`.
- Throughput: one push and one pop per cycle, sustained.
- Handshake: valid never drops without a pop. Data and addr are unchanged while valid && !ready.
- `o_done` is asserted the cycle after the pop that empties the FIFO in DRAIN. With `i_finish` in IDLE, it is asserted the cycle after `i_finish`.
- `o_busy` is registered: high from the cycle after the IDLE exit through DONE.
- Reset asserted mid-operation: all contents are discarded immediately. No `o_done`. Outputs return to reset values asynchronously.

## Test plan
- Basic flow:
  - Stimulus: 4 writes on consecutive cycles (addr 0..3, data = addr×0x11 replicated), ready tied high, then `i_finish`.
  - Required: 4 beats in order; `o_m_last` on addr 3; `o_done` pulses once; `o_beat_cnt` = 4; `o_overflow` = 0.
- Back-pressure:
  - Stimulus: DEPTH = 8, ready low, 8 writes.
  - Required: `count` = 8; data is stable while stalled.
  - Stimulus, continued: a 9th write.
  - Required: `o_overflow` = 1; that entry is dropped.
  - Stimulus, continued: raise ready.
  - Required: exactly 8 beats.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, ready high, write addr 0x20 in the same cycle.
  - Required: no overflow; addr 0x20 emerges 8th after that cycle.
- Late write in DRAIN:
  - Stimulus: `i_finish` with 1 entry left and ready low; then a write of addr 0x7 on the next cycle.
  - Required: `o_m_last` deasserts, then reasserts on addr 0x7 only; `o_done` follows that pop.
- Empty matrix: `i_finish` in IDLE with no writes → `o_done` the next cycle, `o_m_valid` never high, `o_beat_cnt` unchanged.
- Mid-run reset: assert `i_rst_n` = 0 with 3 entries pending → `o_m_valid`, `o_busy`, `o_overflow` and `o_beat_cnt` go to 0 immediately; no `o_done` after release.
